// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared state encoding, halt opcode and default widths
// for the fetch sequencer and its memory port mux.
package fetch_sequencer_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_WDT_CYCLES = 16;
  localparam logic [3:0] HALT_OPCODE = 4'hF;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_ISSUE,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_t;
  function automatic logic is_busy(state_t s);
    return s inside {S_FETCH, S_CAPTURE, S_ISSUE, S_EXEC};
  endfunction
endpackage

// File: rtl/fetch_sequencer_mem_mux.sv
// seq_mem_mux: shared memory port mux; fetch owns the address in FETCH, the
// interpreter owns the whole port in EXEC, and nobody may write otherwise.
module seq_mem_mux #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              i_fetch,
  input  logic              i_exec,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_ii_rw,
  input  logic [ADDR_W-1:0] i_ii_addr,
  input  logic [DATA_W-1:0] i_ii_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [DATA_W-1:0] o_ii_rdata
);
  assign o_mem_addr  = i_exec ? i_ii_addr : i_fetch ? i_pc : '0;
  assign o_mem_we    = i_exec & i_ii_rw;
  assign o_mem_wdata = i_exec ? i_ii_wdata : '0;
  assign o_ii_rdata  = i_mem_rdata;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch/capture/issue/exec controller that hands instructions to an
// external interpreter and lends it the shared memory port while it executes.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                WDT_CYCLES = DEF_WDT_CYCLES,
  parameter logic [ADDR_W-1:0] START_PC   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  input  logic              restart,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ii_inst,
  output logic              ii_start,
  input  logic              ii_done,
  input  logic              ii_mem_rw,
  input  logic [ADDR_W-1:0] ii_mem_addr,
  input  logic [DATA_W-1:0] ii_mem_wdata,
  output logic [DATA_W-1:0] ii_mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              fault
);
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  state_t            r_state, w_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_inst;
  logic [WDT_W-1:0]  r_wdt;
  logic              r_ii_start, r_busy, r_halted, r_fault;
  logic              w_halt_op, w_wdt_exp, w_restart_ok, w_fetch, w_exec;
  assign w_halt_op    = mem_rdata[DATA_W-1 -: 4] == HALT_OPCODE;
  assign w_wdt_exp    = r_wdt == WDT_W'(WDT_CYCLES - 1);
  assign w_restart_ok = restart && (r_state inside {S_IDLE, S_HALT, S_FAULT});
  assign w_fetch      = r_state == S_FETCH;
  assign w_exec       = r_state == S_EXEC;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:    w_nxt = (run && !restart) ? S_FETCH : S_IDLE;
      S_FETCH:   w_nxt = S_CAPTURE;
      S_CAPTURE: w_nxt = w_halt_op ? S_HALT : S_ISSUE;
      S_ISSUE:   w_nxt = S_EXEC;
      // completion beats the watchdog when both land on the same cycle
      S_EXEC:    w_nxt = ii_done ? ((run && !step) ? S_FETCH : S_IDLE)
                                 : (w_wdt_exp ? S_FAULT : S_EXEC);
      S_HALT:    w_nxt = restart ? S_IDLE : S_HALT;
      S_FAULT:   w_nxt = restart ? S_IDLE : S_FAULT;
      default:   w_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= START_PC;
      r_inst     <= '0;
      r_wdt      <= '0;
      r_ii_start <= 1'b0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_ii_start <= w_nxt == S_ISSUE;
      r_busy     <= is_busy(w_nxt);
      r_halted   <= w_nxt == S_HALT;
      r_fault    <= w_nxt == S_FAULT;
      r_wdt      <= (w_exec && w_nxt == S_EXEC) ? r_wdt + 1'b1 : '0;
      if (r_state == S_CAPTURE) begin
        r_inst <= mem_rdata;
        r_pc   <= r_pc + 1'b1;
      end
      if (w_restart_ok) r_pc <= START_PC;
    end
  end
  seq_mem_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .i_fetch    (w_fetch),
    .i_exec     (w_exec),
    .i_pc       (r_pc),
    .i_ii_rw    (ii_mem_rw),
    .i_ii_addr  (ii_mem_addr),
    .i_ii_wdata (ii_mem_wdata),
    .i_mem_rdata(mem_rdata),
    .o_mem_addr (mem_addr),
    .o_mem_we   (mem_we),
    .o_mem_wdata(mem_wdata),
    .o_ii_rdata (ii_mem_rdata)
  );
  assign pc       = r_pc;
  assign ii_inst  = r_inst;
  assign ii_start = r_ii_start;
  assign busy     = r_busy;
  assign halted   = r_halted;
  assign fault    = r_fault;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scoreboard bench with a behavioural memory and interpreter.
module tb_fetch_sequencer;
  logic clk = 0, rst_n = 0, run = 0, step = 0, restart = 0, ii_done = 0, ii_mem_rw = 0;
  logic [7:0] ii_mem_addr = 0;
  logic [15:0] ii_mem_wdata = 0;
  logic [7:0] mem_addr, pc;
  logic mem_we, ii_start, busy, halted, fault;
  logic [15:0] mem_wdata, mem_rdata, ii_inst, ii_mem_rdata;
  logic bd_we = 0;
  logic [7:0] bd_addr = 0;
  logic [15:0] bd_data = 0;
  logic [15:0] mem [256];
  logic [15:0] exp_inst [$];
  logic [23:0] exp_wr [$];
  int n_chk = 0, n_fail = 0, n_start = 0, done_dly = 0;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .restart(restart),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .ii_inst(ii_inst), .ii_start(ii_start), .ii_done(ii_done), .ii_mem_rw(ii_mem_rw),
    .ii_mem_addr(ii_mem_addr), .ii_mem_wdata(ii_mem_wdata), .ii_mem_rdata(ii_mem_rdata),
    .pc(pc), .busy(busy), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // synchronous-read memory with a bench backdoor write port
  always @(posedge clk) begin
    if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
    else if (bd_we) mem[bd_addr] <= bd_data;
    mem_rdata <= mem[mem_addr];
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // interpreter: raises ii_done after done_dly extra EXEC cycles, never if negative
  initial forever begin
    @(negedge clk);
    if (ii_start === 1'b1 && done_dly >= 0) begin
      @(posedge clk);
      repeat (done_dly) @(posedge clk);
      #1 ii_done = 1;
      @(posedge clk);
      #1 ii_done = 0;
    end
  end

  always @(negedge clk) begin
    if (ii_start === 1'b1) begin
      n_start++;
      if (exp_inst.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL ii_start: unexpected start, ii_inst=%0h expected none", ii_inst);
      end else chk("ii_inst", ii_inst, exp_inst.pop_front());
    end
    if (mem_we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL mem_we: unexpected write addr=%0h data=%0h expected none", mem_addr, mem_wdata);
      end else chk("mem_write", {mem_addr, mem_wdata}, exp_wr.pop_front());
    end
  end

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    bd_addr = a; bd_data = d; bd_we = 1;
    @(posedge clk);
    #1 bd_we = 0;
  endtask

  task automatic do_restart();
    @(posedge clk);
    #1 restart = 1;
    @(posedge clk);
    #1 restart = 0;
  endtask

  task automatic wait_start(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (ii_start !== 1'b1 && n < 50);
    chk({nm, "_start_seen"}, ii_start, 1'b1);
  endtask

  task automatic wait_halt(input string nm, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (halted !== 1'b1 && n < budget);
    chk({nm, "_halted"}, halted, 1'b1);
  endtask

  initial begin
    int n, s0;
    #8;
    chk("rst_pc", pc, 0); chk("rst_busy", busy, 0); chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0); chk("rst_start", ii_start, 0); chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0); chk("rst_wdata", mem_wdata, 0); chk("rst_inst", ii_inst, 0);
    #4 rst_n = 1;

    // basic issue then halt
    poke(8'h00, 16'h2005); poke(8'h01, 16'hF000);
    exp_inst.push_back(16'h2005);
    done_dly = 0; run = 1;
    wait_start("t1");
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("t1_refetch_addr", mem_addr, 8'h01); chk("t1_busy", busy, 1);
    wait_halt("t1", 20);
    chk("t1_pc", pc, 8'h02); chk("t1_busy_halt", busy, 0);
    repeat (3) @(negedge clk);
    chk("t1_halt_sticky", halted, 1); chk("t1_pc_hold", pc, 8'h02);
    run = 0;
    do_restart();
    @(negedge clk);
    chk("t1_restart_halted", halted, 0); chk("t1_restart_pc", pc, 0);

    // interpreter store granted only in EXEC (3 EXEC cycles)
    poke(8'h00, 16'h3000);
    ii_mem_rw = 1; ii_mem_addr = 8'h40; ii_mem_wdata = 16'hBEEF;
    exp_inst.push_back(16'h3000);
    repeat (3) exp_wr.push_back({8'h40, 16'hBEEF});
    done_dly = 2; run = 1;
    wait_halt("t2", 40);
    chk("t2_pc", pc, 8'h02); chk("t2_mem40", mem[8'h40], 16'hBEEF);
    run = 0;
    do_restart();
    ii_mem_rw = 0;
    @(negedge clk);
    chk("t2_restart_pc", pc, 0);

    // watchdog fault
    poke(8'h00, 16'h1234);
    exp_inst.push_back(16'h1234);
    done_dly = -1; run = 1;
    wait_start("t3");
    @(posedge clk);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (fault !== 1'b1 && n < 40);
    chk("t3_wdt_cycles", n, 16);
    ii_mem_rw = 1;
    @(negedge clk);
    chk("t3_fault", fault, 1); chk("t3_start", ii_start, 0);
    chk("t3_we", mem_we, 0); chk("t3_busy", busy, 0);
    ii_mem_rw = 0; run = 0;
    do_restart();
    @(negedge clk);
    chk("t3_restart_fault", fault, 0); chk("t3_restart_pc", pc, 0); chk("t3_restart_busy", busy, 0);

    // run through the whole address space and wrap
    for (int i = 0; i < 256; i++) begin
      poke(i[7:0], 16'h1000 | 16'(i));
      exp_inst.push_back(16'h1000 | 16'(i));
    end
    done_dly = 0; run = 1;
    wait_start("t4");
    poke(8'h00, 16'hF000);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(ii_start === 1'b1 && ii_inst === 16'h10FF) && n < 1500);
    chk("t4_last_issue", ii_inst, 16'h10FF); chk("t4_pc_wrap", pc, 8'h00);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t4_halt_no_stall", halted, 1); chk("t4_pc", pc, 8'h01);
    run = 0;
    do_restart();

    // single step, then run dropped mid-instruction with an ignored restart
    poke(8'h00, 16'h2222); poke(8'h01, 16'h3333); poke(8'h02, 16'h5555);
    step = 1; done_dly = 1;
    exp_inst.push_back(16'h2222);
    s0 = n_start; run = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (busy !== 1'b1 && n < 10);
    do begin @(negedge clk); n++; end while (busy !== 1'b0 && n < 30);
    run = 0; step = 0;
    chk("t5_step_idle", busy, 0);
    repeat (8) @(negedge clk);
    chk("t5_step_starts", n_start - s0, 1); chk("t5_step_pc", pc, 8'h01);
    done_dly = 3;
    exp_inst.push_back(16'h3333);
    s0 = n_start; run = 1;
    wait_start("t5b");
    @(posedge clk);
    #1 run = 0; restart = 1;
    @(posedge clk);
    #1 restart = 0;
    repeat (12) @(negedge clk);
    chk("t5_stop_starts", n_start - s0, 1); chk("t5_stop_pc", pc, 8'h02);
    chk("t5_stop_busy", busy, 0); chk("t5_stop_halted", halted, 0);

    // async reset during EXEC
    exp_inst.push_back(16'h5555);
    exp_wr.push_back({8'h41, 16'h1234});
    ii_mem_rw = 1; ii_mem_addr = 8'h41; ii_mem_wdata = 16'h1234;
    done_dly = -1; run = 1;
    wait_start("t6");
    @(negedge clk);
    #1 rst_n = 0;
    #1 chk("t6_async_we", mem_we, 0); chk("t6_async_busy", busy, 0);
    run = 0; ii_mem_rw = 0;
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("t6_pc", pc, 0); chk("t6_busy", busy, 0); chk("t6_fault", fault, 0);
    chk("t6_start", ii_start, 0); chk("t6_addr", mem_addr, 0);

    repeat (4) @(negedge clk);
    chk("inst_queue_empty", exp_inst.size(), 0);
    chk("write_queue_empty", exp_wr.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, memory/PC address width.
REQ-002 Parameter DATA_W, default 16, instruction/data word width.
REQ-003 Parameter WDT_CYCLES, default 16, max EXEC cycles before fault.
REQ-004 Parameter START_PC, default 0, PC value loaded at reset and on restart.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 run  input  1  level; 1 = sequence instructions, 0 = stop at next instruction boundary.
REQ-008 step  input  1  level; 1 = return to IDLE after each completed instruction.
REQ-009 restart  input  1  pulse; in IDLE/HALT/FAULT reloads PC=START_PC and returns to IDLE.
REQ-010 mem_addr  output  ADDR_W  shared memory address.
REQ-011 mem_we  output  1  shared memory write enable.
REQ-012 mem_wdata  output  DATA_W  shared memory write data.
REQ-013 mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_addr with mem_we=0.
REQ-014 ii_inst  output  DATA_W  instruction to interpreter, stable from ISSUE until next fetch capture.
REQ-015 ii_start  output  1  one-cycle start pulse to interpreter.
REQ-016 ii_done  input  1  interpreter completion, sampled each cycle in EXEC.
REQ-017 ii_mem_rw  input  1  interpreter access type, 1 = write.
REQ-018 ii_mem_addr  input  ADDR_W  interpreter data address.
REQ-019 ii_mem_wdata  input  DATA_W  interpreter write data.
REQ-020 ii_mem_rdata  output  DATA_W  mem_rdata forwarded to interpreter.
REQ-021 pc  output  ADDR_W  address of next instruction to fetch.
REQ-022 busy / halted / fault  output  1 each  state status flags.

Function
REQ-023 States SHALL be IDLE, FETCH, CAPTURE, ISSUE, EXEC, HALT, FAULT.
REQ-024 IDLE: run=1 -> FETCH; else stay; busy=0.
REQ-025 FETCH: mem_addr=pc, mem_we=0; -> CAPTURE next cycle.
REQ-026 CAPTURE: latch mem_rdata into instruction register; pc <= pc+1 modulo 2^ADDR_W (0xFF -> 0x00); opcode bits[15:12]=4'hF -> HALT, else -> ISSUE.
REQ-027 ISSUE: ii_start=1 for exactly this cycle; -> EXEC.
REQ-028 EXEC: memory port granted to interpreter (mem_addr=ii_mem_addr, mem_we=ii_mem_rw, mem_wdata=ii_mem_wdata); watchdog counts from 0.
REQ-029 EXEC with ii_done=1: run=1 and step=0 -> FETCH; otherwise -> IDLE.
REQ-030 EXEC with watchdog reaching WDT_CYCLES and ii_done=0 -> FAULT; ii_done on the same cycle wins.
REQ-031 Outside EXEC the interpreter has no memory grant: mem_we SHALL be 0 and ii_mem_* inputs ignored.
REQ-032 run deassert mid-instruction SHALL NOT abort it; stop takes effect at the EXEC->next transition.
REQ-033 HALT: halted=1; left only via restart or reset; run ignored.
REQ-034 FAULT: fault=1, ii_start=0, mem_we=0; left only via restart or reset.
REQ-035 restart in FETCH/CAPTURE/ISSUE/EXEC SHALL be ignored.
REQ-036 busy=1 in FETCH, CAPTURE, ISSUE, EXEC.
REQ-037 Throughput: one instruction per 4 cycles plus interpreter latency; ii_done asserted in the ISSUE-following cycle completes in 4 cycles total.

Reset
REQ-038 On rst_n=0: state=IDLE, pc=START_PC, instruction register=0, watchdog=0, ii_start=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=halted=fault=0.
REQ-039 Reset mid-EXEC SHALL abandon the instruction immediately, with mem_we=0 asynchronously.

Structure
REQ-040 Shared package SHALL hold the state encoding, HALT_OPCODE=4'hF, and default widths.
REQ-041 One sub-module, seq_mem_mux, SHALL implement the fetch/interpreter memory port mux (REQ-028, REQ-031).

Verification
REQ-042 Reset, mem[0]=0x2005, mem[1]=0xF000, run=1, ii_done one cycle after ii_start -> ii_inst=0x2005 with one ii_start, then halted=1, pc=0x02.
REQ-043 EXEC with interpreter ST (ii_mem_rw=1, addr 0x40, data 0xBEEF) -> mem_we=1, mem_addr=0x40, mem_wdata=0xBEEF only during EXEC.
REQ-044 ii_done never asserted -> fault=1 exactly WDT_CYCLES cycles after EXEC entry; restart -> IDLE, pc=START_PC.
REQ-045 pc preset to 0xFF by fetching through the address space -> after CAPTURE pc=0x00, no stall.
REQ-046 step=1, run=1 -> exactly one ii_start, then IDLE; run dropped during EXEC -> instruction completes, no further fetch.
REQ-047 rst_n low during EXEC -> mem_we=0 before the next clock edge; after release, state=IDLE and pc=START_PC.
